// File: rtl/seg7_pkg.sv
// Shared state type and segment constants for the seven-segment scan controller.
package seg7_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRIVE = 2'd1,
      S_BLANK = 2'd2
   } scan_state_e;

   // Digit register reset value: blank bit set, hex value zero.
   localparam logic [4:0] BLANK_DATA = 5'b10000;

   // Entry n holds the {g,f,e,d,c,b,a} pattern for hex digit n (MSB entry is F).
   localparam logic [15:0][6:0] HEX_SEG = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational decode of a 5-bit digit entry {blank, hex} to active-high segments.
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [4:0] data_i,
   output logic [6:0] seg_o
);

   assign seg_o = data_i[4] ? 7'h00 : HEX_SEG[data_i[3:0]];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with per-digit registers.
// Optional inter-digit blanking is built when SEG7_SCAN_BLANK_EN is defined.
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int NDIG      = 4,
   parameter int PRESCALE  = 1000,
   parameter int BLANK_CYC = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic                    wr_en,
   input  logic [$clog2(NDIG)-1:0] wr_addr,
   input  logic [4:0]              wr_data,
   output logic [6:0]              led_out,
   output logic [6:0]              led_out_b,
   output logic [NDIG-1:0]         digit_sel,
   output logic                    frame_tick
);

   localparam int IW   = $clog2(NDIG);
   localparam int CMAX = (PRESCALE > BLANK_CYC) ? PRESCALE : BLANK_CYC;
   localparam int CW   = $clog2(CMAX);
   localparam logic [CW-1:0] DRIVE_LAST = CW'(PRESCALE - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NDIG - 1);
`ifdef SEG7_SCAN_BLANK_EN
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
`endif

   scan_state_e            state_q, state_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   slot_start;
   logic [NDIG-1:0][4:0]   digit_q;
   logic [4:0]             rd_data;
   logic [6:0]             dec_seg;
   logic [6:0]             led_out_q, led_out_d;
   logic [6:0]             led_out_b_q, led_out_b_d;
   logic [NDIG-1:0]        digit_sel_q, digit_sel_d;
   logic                   frame_tick_q, frame_tick_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         cnt_q        <= '0;
         led_out_q    <= '0;
         led_out_b_q  <= 7'h7F;
         digit_sel_q  <= '0;
         frame_tick_q <= 1'b0;
         for (int i = 0; i < NDIG; i++) digit_q[i] <= BLANK_DATA;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         led_out_q    <= led_out_d;
         led_out_b_q  <= led_out_b_d;
         digit_sel_q  <= digit_sel_d;
         frame_tick_q <= frame_tick_d;
         for (int i = 0; i < NDIG; i++)
            if (wr_en && wr_addr == IW'(i)) digit_q[i] <= wr_data;
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      slot_start = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            state_d = S_DRIVE;
            idx_d   = '0;
            cnt_d   = '0;
         end
         S_DRIVE: begin
            if (cnt_q == DRIVE_LAST) begin
               idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
               cnt_d = '0;
`ifdef SEG7_SCAN_BLANK_EN
               state_d = S_BLANK;
`else
               slot_start = 1'b1;
`endif
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`ifdef SEG7_SCAN_BLANK_EN
         S_BLANK: begin
            if (cnt_q == BLANK_LAST) begin
               state_d    = S_DRIVE;
               cnt_d      = '0;
               slot_start = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`endif
         default: begin
            state_d = S_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
         end
      endcase
      if (!enable) begin
         state_d    = S_IDLE;
         idx_d      = '0;
         cnt_d      = '0;
         slot_start = 1'b0;
      end
   end

   // Forward a same-cycle write so the displayed digit never shows stale data.
   assign rd_data = (wr_en && wr_addr == idx_d) ? wr_data : digit_q[idx_d];

   seg7_hex_decode u_dec (
      .data_i (rd_data),
      .seg_o  (dec_seg)
   );

   always_comb begin
      led_out_d    = '0;
      led_out_b_d  = 7'h7F;
      digit_sel_d  = '0;
      frame_tick_d = 1'b0;
      if (state_d != S_IDLE) led_out_b_d = 7'h00;
      if (state_d == S_DRIVE) begin
         digit_sel_d  = NDIG'(1) << idx_d;
         led_out_d    = dec_seg;
         frame_tick_d = slot_start && (idx_d == '0);
      end
   end

   assign led_out    = led_out_q;
   assign led_out_b  = led_out_b_q;
   assign digit_sel  = digit_sel_q;
   assign frame_tick = frame_tick_q;

endmodule
